frame_decoder: RTL and testbench

Parametrised successor to the single-byte sample decoder. It sits between the host byte controller and the modulators, and parses framed byte streams of the form SYNC, CTRL, LEN, then payload. Payload bytes are assembled into multi-byte samples and buffered in an internal FIFO. Samples are delivered to the modulator through a valid/ready handshake. The block returns a per-frame ACK byte and a status byte to the controller.

---
 rtl/frame_decoder_if.sv | 34 +++
 rtl/frame_decoder.sv | 175 +++++++++++++++++
 tb/tb_frame_decoder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/frame_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_decoder_if : controller byte link and sample handshake bundle  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface frame_decoder_if #(
  parameter int SAMPLE_BYTES = 1,
  parameter int FIFO_DEPTH   = 16
);
  localparam int SW = 8 * SAMPLE_BYTES;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    data_rx;
  logic          rx;
  logic [7:0]    data_tx;
  logic          tx;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready;
  logic [7:0]    ctrl;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  modport master (
    output data_rx, rx, sample_ready,
    input  data_tx, tx, sample, sample_valid, ctrl, fifo_level, overflow
  );

  modport slave (
    input  data_rx, rx, sample_ready,
    output data_tx, tx, sample, sample_valid, ctrl, fifo_level, overflow
  );
endinterface
`default_nettype wire

// File: rtl/frame_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_decoder : parses SYNC/CTRL/LEN/payload frames into samples     |
// | buffered in a first-word-fall-through FIFO.            Rev 1.0       |
// +----------------------------------------------------------------------+
module frame_decoder #(
  parameter logic [7:0] SYNC_WORD    = 8'hFF,
  parameter logic [7:0] ACK_WORD     = 8'hA5,
  parameter int         SAMPLE_BYTES = 1,
  parameter int         FIFO_DEPTH   = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  frame_decoder_if.slave  bus
);
  localparam int SW = 8 * SAMPLE_BYTES;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0]    C_LAST_BYTE = 2'(SAMPLE_BYTES - 1);
  localparam logic [LW-1:0] C_FULL_LVL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CTRL    = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_STATUS  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [7:0]    len_q, len_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    samp_cnt_q, samp_cnt_d;
  logic [6:0]    drop_cnt_q, drop_cnt_d;
  logic [6:0]    drop_next;
  logic [SW-1:0] assem_q, assem_d;
  logic [SW-1:0] w_shift;
  logic          tx_q, tx_d;
  logic [7:0]    data_tx_q, data_tx_d;
  logic          overflow_q, overflow_d;
  logic          push_req;

  logic [SW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q;
  logic          w_full, w_push, w_pop;

  // Big-endian assembly: earlier bytes move toward the MSBs.
  assign w_shift = (assem_q << 8) | SW'(bus.data_rx);
  assign w_full  = (level_q == C_FULL_LVL);
  assign w_push  = push_req && !w_full;
  assign w_pop   = valid_q && bus.sample_ready;
  assign level_d = level_q + LW'(w_push) - LW'(w_pop);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    samp_cnt_d = samp_cnt_q;
    drop_cnt_d = drop_cnt_q;
    drop_next  = (drop_cnt_q == 7'h7F) ? drop_cnt_q : drop_cnt_q + 7'd1;
    assem_d    = assem_q;
    tx_d       = 1'b0;
    data_tx_d  = data_tx_q;
    overflow_d = overflow_q;
    push_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rx && bus.data_rx == SYNC_WORD) state_d = S_CTRL;
      end
      S_CTRL: begin
        if (bus.rx) begin
          ctrl_d  = bus.data_rx;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (bus.rx) begin
          len_d     = bus.data_rx;
          tx_d      = 1'b1;
          data_tx_d = ACK_WORD;
          if (bus.data_rx == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            byte_cnt_d = 2'd0;
            samp_cnt_d = 8'd0;
            drop_cnt_d = 7'd0;
            assem_d    = '0;
            state_d    = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.rx) begin
          assem_d = w_shift;
          if (byte_cnt_q == C_LAST_BYTE) begin
            byte_cnt_d = 2'd0;
            push_req   = 1'b1;
            samp_cnt_d = samp_cnt_q + 8'd1;
            if (w_full) begin
              overflow_d = 1'b1;
              drop_cnt_d = drop_next;
            end
            // Status goes out the cycle after the final byte, so form it now.
            if (samp_cnt_q + 8'd1 == len_q) begin
              state_d   = S_STATUS;
              tx_d      = 1'b1;
              data_tx_d = {(drop_cnt_d != 7'd0), drop_cnt_d};
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      S_STATUS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 8'd0;
      len_q      <= 8'd0;
      byte_cnt_q <= 2'd0;
      samp_cnt_q <= 8'd0;
      drop_cnt_q <= 7'd0;
      assem_q    <= '0;
      tx_q       <= 1'b0;
      data_tx_q  <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      assem_q    <= assem_d;
      tx_q       <= tx_d;
      data_tx_q  <= data_tx_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      valid_q <= (level_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= w_shift;
  end

  assign bus.data_tx      = data_tx_q;
  assign bus.tx           = tx_q;
  assign bus.sample       = mem_q[rd_ptr_q];
  assign bus.sample_valid = valid_q;
  assign bus.ctrl         = ctrl_q;
  assign bus.fifo_level   = level_q;
  assign bus.overflow     = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_frame_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_frame_decoder : scoreboard bench, 1-byte/depth-4 and 2-byte DUTs  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_frame_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_decoder_if #(.SAMPLE_BYTES(1), .FIFO_DEPTH(4))  ia ();
  frame_decoder_if #(.SAMPLE_BYTES(2), .FIFO_DEPTH(16)) ib ();

  frame_decoder #(.SAMPLE_BYTES(1), .FIFO_DEPTH(4))  u_a (.clk(clk), .rst(rst), .bus(ia));
  frame_decoder #(.SAMPLE_BYTES(2), .FIFO_DEPTH(16)) u_b (.clk(clk), .rst(rst), .bus(ib));

  int vectors    = 0;
  int miscompares = 0;
  logic [7:0]  exp_tx_a[$];
  logic [7:0]  exp_s_a[$];
  logic [7:0]  exp_tx_b[$];
  logic [15:0] exp_s_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h expected no output", name, act);
  endtask

  // Monitors pop the scoreboard whenever a DUT presents an output.
  always @(negedge clk) begin
    if (!rst) begin
      if (ia.tx) begin
        if (exp_tx_a.size() == 0) miss("a_tx_unexpected", 32'(ia.data_tx));
        else check("a_tx", 32'(ia.data_tx), 32'(exp_tx_a.pop_front()));
      end
      if (ia.sample_valid && ia.sample_ready) begin
        if (exp_s_a.size() == 0) miss("a_sample_unexpected", 32'(ia.sample));
        else check("a_sample", 32'(ia.sample), 32'(exp_s_a.pop_front()));
      end
      if (ib.tx) begin
        if (exp_tx_b.size() == 0) miss("b_tx_unexpected", 32'(ib.data_tx));
        else check("b_tx", 32'(ib.data_tx), 32'(exp_tx_b.pop_front()));
      end
      if (ib.sample_valid && ib.sample_ready) begin
        if (exp_s_b.size() == 0) miss("b_sample_unexpected", 32'(ib.sample));
        else check("b_sample", 32'(ib.sample), 32'(exp_s_b.pop_front()));
      end
    end
  end

  // Byte tasks are entered 1 time unit after a rising edge and return likewise.
  task automatic byte_a(input logic [7:0] b);
    ia.rx = 1'b1; ia.data_rx = b;
    @(posedge clk); #1;
    ia.rx = 1'b0;
  endtask

  task automatic byte_b(input logic [7:0] b);
    ib.rx = 1'b1; ib.data_rx = b;
    @(posedge clk); #1;
    ib.rx = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [7:0] pay3 [6];
    ia.rx = 1'b0; ia.data_rx = 8'h00; ia.sample_ready = 1'b0;
    ib.rx = 1'b0; ib.data_rx = 8'h00; ib.sample_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",       32'(ia.tx), 32'h0);
    check("rst_data_tx",  32'(ia.data_tx), 32'h0);
    check("rst_ctrl",     32'(ia.ctrl), 32'h0);
    check("rst_overflow", 32'(ia.overflow), 32'h0);
    check("rst_valid",    32'(ia.sample_valid), 32'h0);
    check("rst_level",    32'(ia.fifo_level), 32'h0);
    rst = 1'b0;
    idle(1);

    // Basic 1-byte frame
    ia.sample_ready = 1'b1;
    exp_tx_a.push_back(8'hA5); exp_s_a.push_back(8'h11); exp_s_a.push_back(8'h22);
    exp_tx_a.push_back(8'h00);
    byte_a(8'hFF); byte_a(8'h03); byte_a(8'h02);
    check("t1_ack_tx", 32'(ia.tx), 32'h1);
    check("t1_ctrl", 32'(ia.ctrl), 32'h03);
    byte_a(8'h11); byte_a(8'h22);
    check("t1_status_tx", 32'(ia.tx), 32'h1);
    idle(1);
    check("t1_tx_one_cycle", 32'(ia.tx), 32'h0);
    idle(3);

    // 2-byte samples, big-endian
    exp_tx_b.push_back(8'hA5); exp_s_b.push_back(16'hABCD); exp_s_b.push_back(16'h1234);
    exp_tx_b.push_back(8'h00);
    byte_b(8'hFF); byte_b(8'h00); byte_b(8'h02);
    byte_b(8'hAB);
    check("t2_valid_half", 32'(ib.sample_valid), 32'h0);
    byte_b(8'hCD);
    check("t2_valid_first", 32'(ib.sample_valid), 32'h1);
    check("t2_head_first", 32'(ib.sample), 32'h0000ABCD);
    byte_b(8'h12); byte_b(8'h34);
    check("t2_level", 32'(ib.fifo_level), 32'h2);
    ib.sample_ready = 1'b1;
    idle(4);

    // Payload containing SYNC, then LEN=0, then next frame
    exp_tx_a.push_back(8'hA5);
    exp_s_a.push_back(8'hAA); exp_s_a.push_back(8'hFF); exp_s_a.push_back(8'hBB);
    exp_tx_a.push_back(8'h00);
    byte_a(8'hFF); byte_a(8'h07); byte_a(8'h03);
    byte_a(8'hAA); byte_a(8'hFF); byte_a(8'hBB);
    idle(2);
    check("t5_ctrl", 32'(ia.ctrl), 32'h07);
    exp_tx_a.push_back(8'hA5);
    byte_a(8'hFF); byte_a(8'h00); byte_a(8'h00);
    check("t5_len0_ack", 32'(ia.tx), 32'h1);
    exp_tx_a.push_back(8'hA5); exp_s_a.push_back(8'h5C); exp_tx_a.push_back(8'h00);
    byte_a(8'hFF); byte_a(8'h01); byte_a(8'h01); byte_a(8'h5C);
    check("t5_next_status", 32'(ia.tx), 32'h1);
    idle(3);

    // Overflow with sample_ready low, depth 4, N=6
    ia.sample_ready = 1'b0;
    pay3 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    exp_tx_a.push_back(8'hA5); exp_tx_a.push_back(8'h82);
    for (int i = 0; i < 4; i++) exp_s_a.push_back(pay3[i]);
    byte_a(8'hFF); byte_a(8'h02); byte_a(8'h06);
    for (int i = 0; i < 6; i++) byte_a(pay3[i]);
    check("t3_level_sat", 32'(ia.fifo_level), 32'h4);
    check("t3_overflow", 32'(ia.overflow), 32'h1);
    ia.sample_ready = 1'b1;
    idle(6);
    check("t3_drained", 32'(ia.fifo_level), 32'h0);
    exp_tx_a.push_back(8'hA5); exp_s_a.push_back(8'h77); exp_tx_a.push_back(8'h00);
    byte_a(8'hFF); byte_a(8'h02); byte_a(8'h01); byte_a(8'h77);
    idle(2);
    check("t3_overflow_sticky", 32'(ia.overflow), 32'h1);

    // Full FIFO with pop in the same cycle as a completing push
    ia.sample_ready = 1'b0;
    exp_tx_a.push_back(8'hA5); exp_tx_a.push_back(8'h81);
    exp_s_a.push_back(8'h10); exp_s_a.push_back(8'h20);
    exp_s_a.push_back(8'h30); exp_s_a.push_back(8'h40);
    byte_a(8'hFF); byte_a(8'h00); byte_a(8'h05);
    byte_a(8'h10); byte_a(8'h20); byte_a(8'h30); byte_a(8'h40);
    check("t4_full", 32'(ia.fifo_level), 32'h4);
    ia.sample_ready = 1'b1;
    byte_a(8'h50);
    check("t4_level_drop", 32'(ia.fifo_level), 32'h3);
    idle(5);

    // Reset mid-payload with 3 samples queued
    ia.sample_ready = 1'b0;
    exp_tx_a.push_back(8'hA5);
    byte_a(8'hFF); byte_a(8'h04); byte_a(8'h05);
    byte_a(8'h01); byte_a(8'h02); byte_a(8'h03);
    check("t6_level_pre", 32'(ia.fifo_level), 32'h3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_level",    32'(ia.fifo_level), 32'h0);
    check("t6_valid",    32'(ia.sample_valid), 32'h0);
    check("t6_data_tx",  32'(ia.data_tx), 32'h0);
    check("t6_ctrl",     32'(ia.ctrl), 32'h0);
    check("t6_overflow", 32'(ia.overflow), 32'h0);
    rst = 1'b0;
    ia.sample_ready = 1'b1;
    exp_tx_a.push_back(8'hA5); exp_s_a.push_back(8'h3C); exp_tx_a.push_back(8'h00);
    byte_a(8'hFF); byte_a(8'h09); byte_a(8'h01); byte_a(8'h3C);
    idle(3);
    check("t6_ctrl_new", 32'(ia.ctrl), 32'h09);

    check("a_tx_queue_empty",  32'(exp_tx_a.size()), 32'h0);
    check("a_smp_queue_empty", 32'(exp_s_a.size()), 32'h0);
    check("b_tx_queue_empty",  32'(exp_tx_b.size()), 32'h0);
    check("b_smp_queue_empty", 32'(exp_s_b.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
